// File: rtl/ctrl_hazard_unit_pkg.sv
// Shared definitions for the control hazard unit: opcode class patterns,
// class-decode helpers and the per-instruction hazard tag.
package ctrl_hazard_unit_pkg;

    localparam logic [2:0] CF_BR_PAT  = 3'b100;
    localparam logic [3:0] CF_JMP_PAT = 4'b1100;
    localparam logic [3:0] HALT_PAT   = 4'b1111;

    typedef struct packed {
        logic cf;
        logic r7;
        logic hl;
    } hz_tag_t;

    // cls is the top four opcode bits
    function automatic logic is_cf(input logic [3:0] cls);
        return (cls[3:1] == CF_BR_PAT) || (cls == CF_JMP_PAT);
    endfunction

    function automatic logic is_halt(input logic [3:0] cls);
        return (cls == HALT_PAT);
    endfunction

endpackage

// File: rtl/ctrl_hazard_unit_shadow_pipe.sv
// Shadow pipeline of hazard tags shifted in lock-step with the datapath.
// Resolve clears act on pre-shift positions; clr_all overrides everything.
module hazard_shadow_pipe
    import ctrl_hazard_unit_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int RES_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  hz_tag_t          ins_tag,
    input  logic             rel_res,
    input  logic             clr_lo,
    input  logic             clr_all,
    output logic [DEPTH-1:0] cf_s,
    output logic [DEPTH-1:0] r7_s,
    output logic [DEPTH-1:0] hl_s,
    output logic [DEPTH-1:0] hl_r
);

    localparam logic [DEPTH-1:0] LO_MASK  = {DEPTH{1'b1}} >> (DEPTH - 1 - RES_STAGE);
    localparam logic [DEPTH-1:0] REL_MASK = {{(DEPTH-1){1'b0}}, 1'b1} << RES_STAGE;

    logic [DEPTH-1:0] cf_r;
    logic [DEPTH-1:0] r7_r;
    logic [DEPTH-1:0] cf_m_s;
    logic [DEPTH-1:0] r7_m_s;
    logic [DEPTH-1:0] hl_m_s;
    logic [DEPTH-1:0] rel_mask_s;
    logic [DEPTH-1:0] lo_mask_s;

    // Apply resolve clears, then shift/insert, then the watchdog wipe
    always_comb begin
        rel_mask_s = rel_res ? REL_MASK : {DEPTH{1'b0}};
        lo_mask_s  = clr_lo  ? LO_MASK  : {DEPTH{1'b0}};
        cf_m_s     = cf_r & ~rel_mask_s & ~lo_mask_s;
        r7_m_s     = r7_r & ~lo_mask_s;
        hl_m_s     = hl_r & ~lo_mask_s;
        if (clr_all) begin
            cf_s = {DEPTH{1'b0}};
            r7_s = {DEPTH{1'b0}};
            hl_s = {DEPTH{1'b0}};
        end else if (adv) begin
            cf_s = {cf_m_s[DEPTH-2:0], ins_tag.cf};
            r7_s = {r7_m_s[DEPTH-2:0], ins_tag.r7};
            hl_s = {hl_m_s[DEPTH-2:0], ins_tag.hl};
        end else begin
            cf_s = cf_m_s;
            r7_s = r7_m_s;
            hl_s = hl_m_s;
        end
    end

    // Tag state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cf_r <= {DEPTH{1'b0}};
            r7_r <= {DEPTH{1'b0}};
            hl_r <= {DEPTH{1'b0}};
        end else begin
            cf_r <= cf_s;
            r7_r <= r7_s;
            hl_r <= hl_s;
        end
    end

endmodule

// File: rtl/ctrl_hazard_unit.sv
// Fetch-stall, redirect flush, halt detection and stall watchdog driven by a
// shadow pipeline of hazard tags. Every output is a flop.
module ctrl_hazard_unit
    import ctrl_hazard_unit_pkg::*;
#(
    parameter int OPW          = 6,
    parameter int DEPTH        = 4,
    parameter int RES_STAGE    = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 15,
    parameter int WD_W         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adv,
    input  logic                       id_valid,
    input  logic [OPW-1:0]             id_opcode,
    input  logic                       id_r7_dest,
    input  logic                       resolve_valid,
    input  logic                       resolve_redirect,
    output logic                       branch_stall,
    output logic                       r7_stall,
    output logic                       stall_any,
    output logic                       flush,
    output logic                       halt,
    output logic                       wd_err,
    output logic [$clog2(DEPTH+1)-1:0] inflight_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    logic [3:0]       cls_s;
    logic             opc_unused_s;
    hz_tag_t          ins_tag_s;
    logic             rel_s;
    logic             redir_s;
    logic             wd_fire_s;
    logic [DEPTH-1:0] cf_s;
    logic [DEPTH-1:0] r7_s;
    logic [DEPTH-1:0] hl_s;
    logic [DEPTH-1:0] hl_r;
    logic [FW-1:0]    flush_cnt_r;
    logic [FW-1:0]    flush_cnt_s;
    logic [WD_W-1:0]  wd_cnt_r;
    logic [WD_W-1:0]  wd_cnt_s;
    logic [CW-1:0]    cnt_s;

    assign cls_s        = id_opcode[OPW-1:OPW-4];
    assign opc_unused_s = ^id_opcode[OPW-5:0];
    assign rel_s        = resolve_valid && !resolve_redirect;
    assign redir_s      = resolve_valid && resolve_redirect;
    assign wd_fire_s    = (wd_cnt_r == WD_W'(MAX_STALL));

    // Decode tag for insertion; a bubble while flushing or without a valid op
    always_comb begin
        ins_tag_s = '{cf: 1'b0, r7: 1'b0, hl: 1'b0};
        if (id_valid && !flush) begin
            ins_tag_s.cf = is_cf(cls_s);
            ins_tag_s.r7 = id_r7_dest;
            ins_tag_s.hl = is_halt(cls_s);
        end else begin
            ins_tag_s = '{cf: 1'b0, r7: 1'b0, hl: 1'b0};
        end
    end

    hazard_shadow_pipe #(
        .DEPTH     (DEPTH),
        .RES_STAGE (RES_STAGE)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (adv),
        .ins_tag (ins_tag_s),
        .rel_res (rel_s),
        .clr_lo  (redir_s),
        .clr_all (wd_fire_s),
        .cf_s    (cf_s),
        .r7_s    (r7_s),
        .hl_s    (hl_s),
        .hl_r    (hl_r)
    );

    // Flush countdown (a redirect reloads it) and stall watchdog next state
    always_comb begin
        flush_cnt_s = flush_cnt_r;
        wd_cnt_s    = wd_cnt_r;
        if (redir_s) begin
            flush_cnt_s = FW'(FLUSH_CYCLES);
        end else if (flush_cnt_r != {FW{1'b0}}) begin
            flush_cnt_s = flush_cnt_r - FW'(1);
        end else begin
            flush_cnt_s = {FW{1'b0}};
        end
        if (wd_fire_s || adv || !stall_any) begin
            wd_cnt_s = {WD_W{1'b0}};
        end else if (wd_cnt_r < WD_W'(MAX_STALL)) begin
            wd_cnt_s = wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_s = wd_cnt_r;
        end
    end

    // Number of control-flow tags that will be in flight after this edge
    always_comb begin
        cnt_s = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt_s = cnt_s + CW'(cf_s[i]);
        end
    end

    // Counters, sticky flags and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt_r  <= {FW{1'b0}};
            wd_cnt_r     <= {WD_W{1'b0}};
            branch_stall <= 1'b0;
            r7_stall     <= 1'b0;
            stall_any    <= 1'b0;
            flush        <= 1'b0;
            halt         <= 1'b0;
            wd_err       <= 1'b0;
            inflight_cnt <= {CW{1'b0}};
        end else begin
            flush_cnt_r  <= flush_cnt_s;
            wd_cnt_r     <= wd_cnt_s;
            branch_stall <= |cf_s[DEPTH-2:0];
            r7_stall     <= |r7_s;
            stall_any    <= (|cf_s[DEPTH-2:0]) || (|r7_s);
            flush        <= (flush_cnt_s != {FW{1'b0}});
            halt         <= halt || (&hl_r);
            wd_err       <= wd_err || wd_fire_s;
            inflight_cnt <= cnt_s;
        end
    end

endmodule
